// File: rtl/slot_scheduler_pkg.sv
// Shared SSRNet slot-timing definitions: FSM encoding and default timing constants
// reused by the slot scheduler, OCS controller and ToR benches.
package slot_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_DATA   = 2'd2
  } slot_state_t;

  localparam logic [31:0] DEF_CONFIG_DELAY = 32'h0000_0960;
  localparam logic [31:0] DEF_SLOT_LEN     = 32'h0000_5CD0;

endpackage

// File: rtl/slot_scheduler_if.sv
// Control/status bundle between a slot-scheduler owner (master) and the scheduler (slave).
interface slot_scheduler_if #(
  parameter int unsigned P_SLOT_W = 1
);

  logic                i_start;
  logic                i_stop;
  logic                i_resync;
  logic [P_SLOT_W-1:0] o_slot_id;
  logic                o_slot_start;
  logic                o_cfg_window;
  logic                o_tx_window;
  logic [31:0]         o_slot_cnt;
  logic                o_running;

  modport master (
    output i_start, i_stop, i_resync,
    input  o_slot_id, o_slot_start, o_cfg_window, o_tx_window, o_slot_cnt, o_running
  );

  modport slave (
    input  i_start, i_stop, i_resync,
    output o_slot_id, o_slot_start, o_cfg_window, o_tx_window, o_slot_cnt, o_running
  );

endinterface

// File: rtl/slot_scheduler.sv
// Time-slot sequencer for the OCS fabric: each slot is a reconfiguration guard
// (CONFIG) followed by a data phase (DATA); slot_id fans out to switches and ToRs.
module slot_scheduler
  import slot_scheduler_pkg::*;
#(
  parameter logic [31:0] P_CONFIG_DELAY = DEF_CONFIG_DELAY,
  parameter logic [31:0] P_SLOT_LEN     = DEF_SLOT_LEN,
  parameter int unsigned P_SLOT_NUM     = 2,
  parameter int unsigned P_SLOT_W       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  slot_scheduler_if.slave  io
);

  if (!((P_SLOT_LEN > P_CONFIG_DELAY) && (P_CONFIG_DELAY >= 32'd1))) begin : g_bad_timing
    $error("slot_scheduler: need P_SLOT_LEN > P_CONFIG_DELAY >= 1");
  end
  if (((64'd1 << P_SLOT_W) < 64'(P_SLOT_NUM)) || (P_SLOT_NUM < 1)) begin : g_bad_slot_w
    $error("slot_scheduler: P_SLOT_W too narrow for P_SLOT_NUM");
  end

  localparam logic [P_SLOT_W-1:0] LP_LAST_ID = P_SLOT_W'(P_SLOT_NUM - 1);
  localparam logic [31:0]         LP_LAST_CNT = P_SLOT_LEN - 32'd1;

  slot_state_t         r_state;
  logic [P_SLOT_W-1:0] r_slot_id;
  logic [31:0]         r_slot_cnt;
  logic                r_slot_start;
  logic                r_cfg_window;
  logic                r_tx_window;
  logic                r_running;
  logic                r_stop_pend;

  logic                w_last_cnt;
  logic                w_cfg_end;
  logic [31:0]         w_cnt_inc;
  logic [P_SLOT_W-1:0] w_next_id;

  assign w_cnt_inc  = r_slot_cnt + 32'd1;
  assign w_last_cnt = (r_slot_cnt == LP_LAST_CNT);
  assign w_cfg_end  = (w_cnt_inc == P_CONFIG_DELAY);
  assign w_next_id  = (r_slot_id == LP_LAST_ID) ? '0 : r_slot_id + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_slot_id    <= '0;
      r_slot_cnt   <= '0;
      r_slot_start <= 1'b0;
      r_cfg_window <= 1'b0;
      r_tx_window  <= 1'b0;
      r_running    <= 1'b0;
      r_stop_pend  <= 1'b0;
    end else begin
      r_slot_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A simultaneous stop vetoes the start.
          if (io.i_start && !io.i_stop) begin
            r_state      <= ST_CONFIG;
            r_slot_id    <= '0;
            r_slot_cnt   <= '0;
            r_slot_start <= 1'b1;
            r_cfg_window <= 1'b1;
            r_tx_window  <= 1'b0;
            r_running    <= 1'b1;
          end
          r_stop_pend <= 1'b0;
        end
        default: begin
          if (io.i_resync) begin
            r_state      <= ST_CONFIG;
            r_slot_id    <= '0;
            r_slot_cnt   <= '0;
            r_slot_start <= 1'b1;
            r_cfg_window <= 1'b1;
            r_tx_window  <= 1'b0;
            r_stop_pend  <= 1'b0;
          end else if (w_last_cnt) begin
            // A stop seen on the final cycle still ends the run at this boundary.
            if (r_stop_pend || io.i_stop) begin
              r_state      <= ST_IDLE;
              r_slot_id    <= '0;
              r_slot_cnt   <= '0;
              r_cfg_window <= 1'b0;
              r_tx_window  <= 1'b0;
              r_running    <= 1'b0;
            end else begin
              r_state      <= ST_CONFIG;
              r_slot_id    <= w_next_id;
              r_slot_cnt   <= '0;
              r_slot_start <= 1'b1;
              r_cfg_window <= 1'b1;
              r_tx_window  <= 1'b0;
            end
            r_stop_pend <= 1'b0;
          end else begin
            r_slot_cnt <= w_cnt_inc;
            if (io.i_stop) begin
              r_stop_pend <= 1'b1;
            end
            if ((r_state == ST_CONFIG) && w_cfg_end) begin
              r_state      <= ST_DATA;
              r_cfg_window <= 1'b0;
              r_tx_window  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign io.o_slot_id    = r_slot_id;
  assign io.o_slot_cnt   = r_slot_cnt;
  assign io.o_slot_start = r_slot_start;
  assign io.o_cfg_window = r_cfg_window;
  assign io.o_tx_window  = r_tx_window;
  assign io.o_running    = r_running;

endmodule

// File: tb/tb_slot_scheduler.sv
// Directed and randomized bench for slot_scheduler, compared cycle by cycle
// against a slot/offset reference model.
module tb_slot_scheduler;

  localparam int CD  = 4;
  localparam int LEN = 10;
  localparam int NUM = 2;
  localparam int SW  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  slot_scheduler_if #(.P_SLOT_W(SW)) bus ();

  slot_scheduler #(
    .P_CONFIG_DELAY(32'(CD)),
    .P_SLOT_LEN    (32'(LEN)),
    .P_SLOT_NUM    (NUM),
    .P_SLOT_W      (SW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: whether running, which slot, offset inside slot, and
  // whether the current cycle opened a slot.
  bit m_run;
  int m_slot;
  int m_off;
  bit m_new;
  bit m_pend;

  function automatic void model_reset();
    m_run = 0; m_slot = 0; m_off = 0; m_new = 0; m_pend = 0;
  endfunction

  function automatic void model_step(input bit s, input bit p, input bit r);
    m_new = 0;
    if (!m_run) begin
      if (s && !p) begin
        m_run = 1; m_slot = 0; m_off = 0; m_new = 1;
      end
    end else if (r) begin
      m_slot = 0; m_off = 0; m_new = 1; m_pend = 0;
    end else begin
      m_pend = m_pend | p;
      if (m_off == LEN - 1) begin
        if (m_pend) begin
          m_run = 0; m_slot = 0; m_off = 0;
        end else begin
          m_slot = (m_slot + 1) % NUM; m_off = 0; m_new = 1;
        end
        m_pend = 0;
      end else begin
        m_off = m_off + 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":slot_id"},    32'(bus.o_slot_id),    32'(m_slot));
    chk({ph, ":slot_cnt"},   bus.o_slot_cnt,        32'(m_off));
    chk({ph, ":slot_start"}, 32'(bus.o_slot_start), 32'(m_new));
    chk({ph, ":cfg_window"}, 32'(bus.o_cfg_window), 32'(m_run && (m_off < CD)));
    chk({ph, ":tx_window"},  32'(bus.o_tx_window),  32'(m_run && (m_off >= CD)));
    chk({ph, ":running"},    32'(bus.o_running),    32'(m_run));
  endtask

  task automatic cycle(input string ph, input bit s, input bit p, input bit r);
    bus.i_start = s; bus.i_stop = p; bus.i_resync = r;
    @(posedge clk);
    if (rst_n) model_step(s, p, r); else model_reset();
    #1;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_resync = 1'b0;
    check_all(ph);
  endtask

  task automatic run_until(input string ph, input int slot, input int off);
    int k = 0;
    while (!(m_run && m_slot == slot && m_off == off) && k < 4 * LEN) begin
      cycle(ph, 0, 0, 0);
      k++;
    end
    chk({ph, ":reach_point"}, 32'(m_run && m_slot == slot && m_off == off), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_resync = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    cycle("idle", 0, 0, 0);

    // Start at cycle 0; first slot opens at cycle 1, second at cycle 11.
    cycle("start", 1, 0, 0);
    chk("start:slot_start", 32'(bus.o_slot_start), 32'd1);
    chk("start:cfg", 32'(bus.o_cfg_window), 32'd1);
    for (int k = 2; k <= 11; k++) begin
      cycle("slot0", 0, 0, 0);
      if (k == 5) chk("c5:tx", 32'(bus.o_tx_window), 32'd1);
      if (k == 10) chk("c10:tx", 32'(bus.o_tx_window), 32'd1);
      if (k == 11) begin
        chk("c11:slot_start", 32'(bus.o_slot_start), 32'd1);
        chk("c11:slot_id", 32'(bus.o_slot_id), 32'd1);
      end
    end
    cycle("slot1_start_ignored", 1, 0, 0);
    for (int k = 0; k < 9; k++) cycle("slot1", 0, 0, 0);
    chk("third:slot_id", 32'(bus.o_slot_id), 32'd0);
    chk("third:slot_start", 32'(bus.o_slot_start), 32'd1);

    // Stop at slot 0 cnt 6: slot finishes through cnt 9, then idle.
    run_until("to_stop", 0, 6);
    cycle("stop", 0, 1, 0);
    for (int k = 0; k < 2; k++) cycle("drain", 0, 0, 0);
    chk("drain:cnt9", bus.o_slot_cnt, 32'd9);
    chk("drain:running", 32'(bus.o_running), 32'd1);
    cycle("stopped", 0, 0, 0);
    chk("stopped:running", 32'(bus.o_running), 32'd0);
    chk("stopped:slot_id", 32'(bus.o_slot_id), 32'd0);
    for (int k = 0; k < 12; k++) cycle("idle_after_stop", 0, 0, k == 3);

    // Resync at slot 1 cnt 7.
    cycle("restart", 1, 0, 0);
    run_until("to_resync", 1, 7);
    cycle("resync", 0, 0, 1);
    chk("resync:slot_id", 32'(bus.o_slot_id), 32'd0);
    chk("resync:cnt", bus.o_slot_cnt, 32'd0);
    chk("resync:cfg", 32'(bus.o_cfg_window), 32'd1);
    chk("resync:slot_start", 32'(bus.o_slot_start), 32'd1);

    // Pending stop cleared by resync; resync+stop keeps running.
    run_until("to_pend", 0, 5);
    cycle("pend_stop", 0, 1, 0);
    cycle("resync_clears", 0, 0, 1);
    cycle("resync_stop", 0, 1, 1);
    for (int k = 0; k < 2 * LEN; k++) cycle("after_resync", 0, 0, 0);
    chk("after_resync:running", 32'(bus.o_running), 32'd1);

    // Stop on the last cycle of a slot.
    run_until("to_last", 1, LEN - 1);
    cycle("stop_last", 0, 1, 0);
    chk("stop_last:running", 32'(bus.o_running), 32'd0);

    // Start and stop together in idle.
    cycle("start_stop", 1, 1, 0);
    for (int k = 0; k < 20; k++) begin
      cycle("veto", 0, 0, 0);
      chk("veto:running", 32'(bus.o_running), 32'd0);
    end

    // Asynchronous reset mid-slot (slot 1 cnt 3), held 5 cycles.
    cycle("pre_rst", 1, 0, 0);
    run_until("to_rst", 1, 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    for (int k = 0; k < 5; k++) cycle("in_rst", 1, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle("post_rst", 0, 0, 0);
    chk("post_rst:running", 32'(bus.o_running), 32'd0);

    // Randomized control pulses.
    for (int k = 0; k < 800; k++) begin
      cycle("rand",
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_scheduler.md
SLOT_SCHEDULER -- requirements
Module: slot_scheduler

Interface
REQ-001 SHALL have parameter P_CONFIG_DELAY, default 32'h0000_0960, meaning cycles of OCS reconfiguration guard at the start of each slot.
REQ-002 SHALL have parameter P_SLOT_LEN, default 32'h0000_5CD0, meaning total cycles per slot, guard included.
REQ-003 SHALL have parameter P_SLOT_NUM, default 2, meaning number of slots per cycle; slot_id wraps modulo this value.
REQ-004 SHALL have parameter P_SLOT_W, default 1, meaning width of o_slot_id, with 2**P_SLOT_W >= P_SLOT_NUM.
REQ-005 i_clk  input  1  single clock; all logic is on its rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 i_start  input  1  single-cycle pulse that begins scheduling from IDLE.
REQ-008 i_stop  input  1  single-cycle pulse requesting halt at the next slot boundary.
REQ-009 i_resync  input  1  single-cycle pulse that restarts at slot 0 immediately while running.
REQ-010 o_slot_id  output  P_SLOT_W  current slot index; drives OCS switch modules and ToR schedulers.
REQ-011 o_slot_start  output  1  one-cycle pulse on the first cycle of every slot.
REQ-012 o_cfg_window  output  1  high during the guard phase, when ToRs must not transmit.
REQ-013 o_tx_window  output  1  high during the data phase.
REQ-014 o_slot_cnt  output  32  cycle offset within the current slot, starting at 0.
REQ-015 o_running  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, CONFIG and DATA.
REQ-017 IDLE + i_start (without i_stop): next cycle the block SHALL be in CONFIG, with o_slot_id=0, o_slot_cnt=0 and o_slot_start=1.
REQ-018 CONFIG SHALL last exactly P_CONFIG_DELAY cycles (o_slot_cnt 0..P_CONFIG_DELAY-1), with o_cfg_window=1 and o_tx_window=0.
REQ-019 DATA SHALL last exactly P_SLOT_LEN-P_CONFIG_DELAY cycles, with o_cfg_window=0 and o_tx_window=1.
REQ-020 When o_slot_cnt=P_SLOT_LEN-1, the next cycle SHALL set o_slot_cnt=0, state CONFIG and o_slot_start=1, and o_slot_id SHALL advance, wrapping P_SLOT_NUM-1 -> 0.
REQ-021 o_slot_id SHALL change only on slot-boundary cycles, never mid-slot.
REQ-022 i_stop while running SHALL be latched (pending); at the next boundary the block SHALL enter IDLE instead of a new slot, and the pending flag SHALL clear.
REQ-023 i_stop and i_start together in IDLE: stop SHALL win and the block SHALL remain IDLE.
REQ-024 i_start while running SHALL be ignored.
REQ-025 i_resync while running SHALL force the next cycle to CONFIG, with o_slot_id=0, o_slot_cnt=0, o_slot_start=1, and SHALL clear any pending stop.
REQ-026 i_resync in IDLE SHALL be ignored.
REQ-027 i_resync and i_stop in the same cycle: resync SHALL take effect and stop SHALL be dropped.
REQ-028 o_cfg_window and o_tx_window SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.
REQ-030 Counter arithmetic SHALL be 32-bit unsigned; P_SLOT_LEN > P_CONFIG_DELAY >= 1 SHALL be enforced by an elaboration-time check.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately force state IDLE, o_slot_id=0, o_slot_cnt=0, o_slot_start=0, o_cfg_window=0, o_tx_window=0, o_running=0, and clear the pending stop.
REQ-032 Reset asserted mid-slot SHALL abort the slot, and after release the block SHALL wait for i_start.

Structure
REQ-033 The state encoding and default timing constants (P_CONFIG_DELAY, P_SLOT_LEN) SHALL live in the shared SSRNet package, so the OCS controller and ToR benches reuse them.
REQ-034 The block SHALL be a single module with no sub-modules; it SHALL be instantiated inside the OCS controller to drive the o_slot_id fan-out.

Verification (P_CONFIG_DELAY=4, P_SLOT_LEN=10, P_SLOT_NUM=2)
REQ-035 Start pulse at cycle 0 -> o_slot_start at cycle 1, o_cfg_window cycles 1-4, o_tx_window cycles 5-10, and a second o_slot_start at cycle 11 with o_slot_id=1.
REQ-036 Run 3 slots -> o_slot_id sequence 0,1,0, and each change SHALL coincide with o_slot_start.
REQ-037 i_stop at slot-0 cnt=6 -> slot completes through cnt=9, then o_running=0 and o_slot_id=0, with no further o_slot_start.
REQ-038 i_resync at slot-1 cnt=7 -> next cycle o_slot_id=0, o_slot_cnt=0, o_cfg_window=1, o_slot_start=1.
REQ-039 i_start and i_stop together in IDLE -> o_running stays 0 for 20 cycles.
REQ-040 i_rst_n low at slot-1 cnt=3, released 5 cycles later -> all outputs 0 and no activity until the next i_start.
